// File: rtl/board_io_if.sv
// Board I/O bundle between the SoC GPIO side and the board I/O conditioner.
// master = SoC/board driver, slave = conditioner.
interface board_io_if #(
    parameter int NUM_BTN  = 1,
    parameter int NUM_LED  = 2,
    parameter int PWM_BITS = 8
);
    logic [NUM_BTN-1:0]          btn_pad;
    logic [NUM_BTN-1:0]          btn_clr;
    logic [NUM_BTN-1:0]          btn_level;
    logic [NUM_BTN-1:0]          btn_press;
    logic [NUM_BTN-1:0]          btn_sticky;
    logic [NUM_BTN-1:0]          btn_long;
    logic [NUM_LED-1:0]          led_pad;
    logic [NUM_LED-1:0]          led_en;
    logic [NUM_LED*PWM_BITS-1:0] led_duty;

    modport master (
        output btn_pad, btn_clr, led_en, led_duty,
        input  btn_level, btn_press, btn_sticky, btn_long, led_pad
    );

    modport slave (
        input  btn_pad, btn_clr, led_en, led_duty,
        output btn_level, btn_press, btn_sticky, btn_long, led_pad
    );
endinterface

// File: rtl/board_io_conditioner.sv
// Button sync/debounce/press/sticky and per-LED PWM dimming for the board pads.
// Optional long-press detector enabled by defining BOARD_IO_LONGPRESS_EN.
module board_io_conditioner #(
    parameter int NUM_BTN          = 1,
    parameter int NUM_LED          = 2,
    parameter int DEBOUNCE_CYCLES  = 120000,
    parameter int PWM_BITS         = 8,
    parameter int PWM_PRESCALE     = 47,
    parameter int BTN_ACTIVE_LOW   = 1,
    parameter int LED_ACTIVE_LOW   = 0,
    parameter int LONGPRESS_CYCLES = 12000000
) (
    input logic       io_mainClk,
    input logic       io_asyncReset_n,
    board_io_if.slave io
);
    localparam int DW = $clog2(DEBOUNCE_CYCLES);
    localparam int PW = (PWM_PRESCALE > 0) ? $clog2(PWM_PRESCALE + 1) : 1;
    localparam logic [DW-1:0] DMAX = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [PW-1:0] PMAX = PW'(PWM_PRESCALE);
    localparam logic [NUM_BTN-1:0] BTN_IDLE = (BTN_ACTIVE_LOW != 0) ? '1 : '0;
    localparam logic [NUM_LED-1:0] LED_OFF = (LED_ACTIVE_LOW != 0) ? '1 : '0;

    if (NUM_BTN < 1 || NUM_BTN > 8 || NUM_LED < 1 || NUM_LED > 8 ||
        DEBOUNCE_CYCLES < 2 || LONGPRESS_CYCLES < 2) begin : g_bad_cfg
        $error("board_io_conditioner: parameter out of range");
    end

    logic [NUM_BTN-1:0] s1_q, s2_q, sync;
    logic [NUM_BTN-1:0] stable_q, stable_d, prev_q;
    logic [NUM_BTN-1:0] press_q, press_d, sticky_q, sticky_d;
    logic [DW-1:0]      dcnt_q [NUM_BTN];
    logic [DW-1:0]      dcnt_d [NUM_BTN];

    logic [PW-1:0]       pre_q, pre_d;
    logic                tick, wrap;
    logic [PWM_BITS-1:0] pcnt_q, pcnt_d;
    logic [PWM_BITS-1:0] shadow_q [NUM_LED];
    logic [PWM_BITS-1:0] shadow_d [NUM_LED];
    logic [NUM_LED-1:0]  lit, led_q;

    always_comb begin
        sync     = (BTN_ACTIVE_LOW != 0) ? ~s2_q : s2_q;
        stable_d = stable_q;
        for (int i = 0; i < NUM_BTN; i++) begin
            dcnt_d[i] = '0;
            if (sync[i] != stable_q[i]) begin
                if (dcnt_q[i] == DMAX) stable_d[i] = ~stable_q[i];
                else                   dcnt_d[i] = dcnt_q[i] + 1'b1;
            end
        end
        press_d  = stable_q & ~prev_q;
        // A press visible now or about to be visible wins over a clear.
        sticky_d = press_d | press_q | (sticky_q & ~io.btn_clr);
    end

    always_comb begin
        tick   = (pre_q == PMAX);
        pre_d  = tick ? '0 : pre_q + 1'b1;
        wrap   = tick && (pcnt_q == '1);
        pcnt_d = tick ? pcnt_q + 1'b1 : pcnt_q;
        for (int i = 0; i < NUM_LED; i++) begin
            shadow_d[i] = wrap ? io.led_duty[i*PWM_BITS +: PWM_BITS]
                               : shadow_q[i];
            lit[i] = io.led_en[i] &&
                     ((shadow_q[i] == '1) || (pcnt_q < shadow_q[i]));
        end
    end

    always_ff @(posedge io_mainClk or negedge io_asyncReset_n) begin
        if (!io_asyncReset_n) begin
            s1_q     <= BTN_IDLE;
            s2_q     <= BTN_IDLE;
            stable_q <= '0;
            prev_q   <= '0;
            press_q  <= '0;
            sticky_q <= '0;
            for (int i = 0; i < NUM_BTN; i++) dcnt_q[i] <= '0;
            pre_q    <= '0;
            pcnt_q   <= '0;
            for (int i = 0; i < NUM_LED; i++) shadow_q[i] <= '0;
            led_q    <= LED_OFF;
        end else begin
            s1_q     <= io.btn_pad;
            s2_q     <= s1_q;
            stable_q <= stable_d;
            prev_q   <= stable_q;
            press_q  <= press_d;
            sticky_q <= sticky_d;
            for (int i = 0; i < NUM_BTN; i++) dcnt_q[i] <= dcnt_d[i];
            pre_q    <= pre_d;
            pcnt_q   <= pcnt_d;
            for (int i = 0; i < NUM_LED; i++) shadow_q[i] <= shadow_d[i];
            led_q    <= lit ^ LED_OFF;
        end
    end

    assign io.btn_level  = stable_q;
    assign io.btn_press  = press_q;
    assign io.btn_sticky = sticky_q;
    assign io.led_pad    = led_q;

`ifdef BOARD_IO_LONGPRESS_EN
    localparam int LW = $clog2(LONGPRESS_CYCLES);
    localparam logic [LW-1:0] LMAX = LW'(LONGPRESS_CYCLES - 1);

    logic [LW-1:0]      lp_q [NUM_BTN];
    logic [LW-1:0]      lp_d [NUM_BTN];
    logic [NUM_BTN-1:0] done_q, done_d, long_q, long_d;

    // Counter parks at LMAX; done flag limits it to one pulse per press.
    always_comb begin
        for (int i = 0; i < NUM_BTN; i++) begin
            lp_d[i]   = lp_q[i];
            done_d[i] = done_q[i];
            long_d[i] = 1'b0;
            if (!stable_q[i]) begin
                lp_d[i]   = '0;
                done_d[i] = 1'b0;
            end else if (lp_q[i] == LMAX) begin
                long_d[i] = ~done_q[i];
                done_d[i] = 1'b1;
            end else begin
                lp_d[i] = lp_q[i] + 1'b1;
            end
        end
    end

    always_ff @(posedge io_mainClk or negedge io_asyncReset_n) begin
        if (!io_asyncReset_n) begin
            for (int i = 0; i < NUM_BTN; i++) lp_q[i] <= '0;
            done_q <= '0;
            long_q <= '0;
        end else begin
            for (int i = 0; i < NUM_BTN; i++) lp_q[i] <= lp_d[i];
            done_q <= done_d;
            long_q <= long_d;
        end
    end

    assign io.btn_long = long_q;
`else
    assign io.btn_long = '0;
`endif
endmodule

// File: tb/tb_board_io_conditioner.sv
// Scoreboard bench for board_io_conditioner (debounce 16, 4-bit PWM, prescale 0).
// Long-press checks follow BOARD_IO_LONGPRESS_EN.
module tb_board_io_conditioner;
    localparam int NB = 1;
    localparam int NL = 2;
    localparam int PB = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    board_io_if #(.NUM_BTN(NB), .NUM_LED(NL), .PWM_BITS(PB)) bus ();

    board_io_conditioner #(
        .NUM_BTN(NB), .NUM_LED(NL), .DEBOUNCE_CYCLES(16),
        .PWM_BITS(PB), .PWM_PRESCALE(0), .BTN_ACTIVE_LOW(1),
        .LED_ACTIVE_LOW(0), .LONGPRESS_CYCLES(64)
    ) dut (
        .io_mainClk(clk),
        .io_asyncReset_n(rst_n),
        .io(bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        string tag;
        int    val;
    } exp_t;

    exp_t sb[$];
    int errors = 0;
    int checks = 0;

    function automatic void push(string t, int v);
        sb.push_back('{t, v});
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        int obs[$];
        bus.btn_pad  = '1;
        bus.btn_clr  = '0;
        bus.led_en   = '0;
        bus.led_duty = '0;
        #1 rst_n = 1'b0;
        push("rst_led_pad", 0);
        push("rst_level", 0);
        push("rst_press", 0);
        push("rst_sticky", 0);
        push("rst_long", 0);
        #2;
        obs.push_back(int'(bus.led_pad));
        obs.push_back(int'(bus.btn_level));
        obs.push_back(int'(bus.btn_press));
        obs.push_back(int'(bus.btn_sticky));
        obs.push_back(int'(bus.btn_long));
        #19 rst_n = 1'b1;
        push("idle_level", 0);
        repeat (5) step();
        obs.push_back(int'(bus.btn_level));
        foreach (obs[k]) begin
            exp_t e;
            e = sb.pop_front();
            checks++;
            if (obs[k] !== e.val) begin
                errors++;
                $display("FAIL %s: got %0d expected %0d", e.tag, obs[k], e.val);
            end
        end
    endtask

    task automatic test_clean_press();
        int obs[$];
        int lvl, pf, pw, sf;
        step();
        bus.btn_pad = 1'b0;
        push("press_level_cycle", 18);
        push("press_first_cycle", 19);
        push("press_width", 1);
        push("sticky_first_cycle", 19);
        lvl = -1; pf = -1; pw = 0; sf = -1;
        for (int k = 1; k <= 40; k++) begin
            step();
            if (bus.btn_level[0] && lvl < 0) lvl = k;
            if (bus.btn_press[0]) begin
                pw++;
                if (pf < 0) pf = k;
            end
            if (bus.btn_sticky[0] && sf < 0) sf = k;
        end
        obs.push_back(lvl); obs.push_back(pf);
        obs.push_back(pw);  obs.push_back(sf);
        bus.btn_pad = 1'b1;
        push("release_press_count", 0);
        push("release_level", 0);
        push("release_sticky", 1);
        pw = 0;
        repeat (40) begin
            step();
            if (bus.btn_press[0]) pw++;
        end
        obs.push_back(pw);
        obs.push_back(int'(bus.btn_level[0]));
        obs.push_back(int'(bus.btn_sticky[0]));
        bus.btn_clr = 1'b1;
        push("clear_sticky", 0);
        step();
        bus.btn_clr = 1'b0;
        obs.push_back(int'(bus.btn_sticky[0]));
        foreach (obs[k]) begin
            exp_t e;
            e = sb.pop_front();
            checks++;
            if (obs[k] !== e.val) begin
                errors++;
                $display("FAIL %s: got %0d expected %0d", e.tag, obs[k], e.val);
            end
        end
    endtask

    task automatic test_bounce();
        int obs[$];
        int lvl, pf, pc;
        step();
        bus.btn_pad = 1'b0;
        push("bounce_level_cycle", 30);
        push("bounce_press_cycle", 31);
        push("bounce_press_count", 1);
        lvl = -1; pf = -1; pc = 0;
        for (int k = 1; k <= 60; k++) begin
            step();
            if (bus.btn_level[0] && lvl < 0) lvl = k;
            if (bus.btn_press[0]) begin
                pc++;
                if (pf < 0) pf = k;
            end
            if (k == 10) bus.btn_pad = 1'b1;
            if (k == 12) bus.btn_pad = 1'b0;
        end
        obs.push_back(lvl); obs.push_back(pf); obs.push_back(pc);
        bus.btn_pad = 1'b1;
        repeat (40) step();
        bus.btn_clr = 1'b1;
        step();
        bus.btn_clr = 1'b0;
        foreach (obs[k]) begin
            exp_t e;
            e = sb.pop_front();
            checks++;
            if (obs[k] !== e.val) begin
                errors++;
                $display("FAIL %s: got %0d expected %0d", e.tag, obs[k], e.val);
            end
        end
    endtask

    task automatic test_sticky_collision();
        int obs[$];
        step();
        bus.btn_pad = 1'b0;
        push("coll_press_c19", 1);
        push("coll_sticky", 1);
        push("coll_sticky_hold", 1);
        push("clr_alone", 0);
        repeat (19) step();
        obs.push_back(int'(bus.btn_press[0]));
        bus.btn_clr = 1'b1;
        step();
        bus.btn_clr = 1'b0;
        obs.push_back(int'(bus.btn_sticky[0]));
        repeat (5) step();
        obs.push_back(int'(bus.btn_sticky[0]));
        bus.btn_clr = 1'b1;
        step();
        bus.btn_clr = 1'b0;
        obs.push_back(int'(bus.btn_sticky[0]));
        bus.btn_pad = 1'b1;
        repeat (40) step();
        foreach (obs[k]) begin
            exp_t e;
            e = sb.pop_front();
            checks++;
            if (obs[k] !== e.val) begin
                errors++;
                $display("FAIL %s: got %0d expected %0d", e.tag, obs[k], e.val);
            end
        end
    endtask

    task automatic test_pwm();
        int obs[$];
        int pat[3][2] = '{'{4, 11}, '{15, 0}, '{0, 15}};
        int d0, d1, c0, c1, found, prev;
        bus.led_en = 2'b11;
        for (int p = 0; p < 3; p++) begin
            d0 = pat[p][0];
            d1 = pat[p][1];
            bus.led_duty = {4'(d1), 4'(d0)};
            push($sformatf("pwm_led0_duty%0d", d0), (d0 == 15) ? 32 : 2 * d0);
            push($sformatf("pwm_led1_duty%0d", d1), (d1 == 15) ? 32 : 2 * d1);
            repeat (40) step();
            c0 = 0; c1 = 0;
            repeat (32) begin
                step();
                c0 += int'(bus.led_pad[0]);
                c1 += int'(bus.led_pad[1]);
            end
            obs.push_back(c0); obs.push_back(c1);
        end
        bus.led_en = 2'b01;
        push("en_off_led1", 0);
        step();
        obs.push_back(int'(bus.led_pad[1]));
        bus.led_en = 2'b11;
        push("en_on_led1", 1);
        step();
        obs.push_back(int'(bus.led_pad[1]));
        bus.led_duty = {4'd0, 4'd4};
        push("pwm_change_before_wrap", 4);
        push("pwm_change_after_wrap", 12);
        repeat (40) step();
        found = 0;
        prev  = int'(bus.led_pad[0]);
        for (int k = 0; k < 40; k++) begin
            step();
            if (prev == 0 && bus.led_pad[0]) begin
                found = 1;
                break;
            end
            prev = int'(bus.led_pad[0]);
        end
        if (found != 0) begin
            c0 = 1; c1 = 0;
            for (int j = 1; j < 32; j++) begin
                step();
                if (j < 16) c0 += int'(bus.led_pad[0]);
                else        c1 += int'(bus.led_pad[0]);
                if (j == 6) bus.led_duty[3:0] = 4'd12;
            end
        end else begin
            c0 = -1; c1 = -1;
        end
        obs.push_back(c0); obs.push_back(c1);
        foreach (obs[k]) begin
            exp_t e;
            e = sb.pop_front();
            checks++;
            if (obs[k] !== e.val) begin
                errors++;
                $display("FAIL %s: got %0d expected %0d", e.tag, obs[k], e.val);
            end
        end
    endtask

    task automatic test_longpress();
        int obs[$];
        int lvl, lf, lc;
        for (int r = 0; r < 2; r++) begin
            step();
            bus.btn_pad = 1'b0;
`ifdef BOARD_IO_LONGPRESS_EN
            push($sformatf("long_count_p%0d", r), 1);
            push($sformatf("long_offset_p%0d", r), 64);
`else
            push($sformatf("long_count_p%0d", r), 0);
`endif
            lvl = -1; lf = -1; lc = 0;
            for (int k = 1; k <= 200; k++) begin
                step();
                if (bus.btn_level[0] && lvl < 0) lvl = k;
                if (bus.btn_long[0]) begin
                    lc++;
                    if (lf < 0) lf = k;
                end
            end
            obs.push_back(lc);
`ifdef BOARD_IO_LONGPRESS_EN
            obs.push_back((lvl < 0 || lf < 0) ? -1 : lf - lvl);
`endif
            bus.btn_pad = 1'b1;
            repeat (40) step();
        end
        bus.btn_clr = 1'b1;
        step();
        bus.btn_clr = 1'b0;
        foreach (obs[k]) begin
            exp_t e;
            e = sb.pop_front();
            checks++;
            if (obs[k] !== e.val) begin
                errors++;
                $display("FAIL %s: got %0d expected %0d", e.tag, obs[k], e.val);
            end
        end
    endtask

    task automatic test_midop_reset();
        int obs[$];
        int first, pc;
        bus.led_en   = 2'b11;
        bus.led_duty = {4'd8, 4'd8};
        bus.btn_pad  = 1'b0;
        push("pre_rst_level", 1);
        push("pre_rst_sticky", 1);
        repeat (30) step();
        obs.push_back(int'(bus.btn_level[0]));
        obs.push_back(int'(bus.btn_sticky[0]));
        #2 rst_n = 1'b0;
        push("midrst_led_pad", 0);
        push("midrst_level", 0);
        push("midrst_press", 0);
        push("midrst_sticky", 0);
        push("midrst_long", 0);
        #1;
        obs.push_back(int'(bus.led_pad));
        obs.push_back(int'(bus.btn_level));
        obs.push_back(int'(bus.btn_press));
        obs.push_back(int'(bus.btn_sticky));
        obs.push_back(int'(bus.btn_long));
        bus.btn_pad = 1'b1;
        repeat (3) step();
        #2 rst_n = 1'b1;
        push("first_lit_cycle", 17);
        push("post_rst_press_count", 0);
        first = -1; pc = 0;
        for (int k = 1; k <= 30; k++) begin
            step();
            if (bus.led_pad[0] && first < 0) first = k;
            if (bus.btn_press[0]) pc++;
        end
        obs.push_back(first);
        obs.push_back(pc);
        foreach (obs[k]) begin
            exp_t e;
            e = sb.pop_front();
            checks++;
            if (obs[k] !== e.val) begin
                errors++;
                $display("FAIL %s: got %0d expected %0d", e.tag, obs[k], e.val);
            end
        end
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_sticky_collision();
        test_pwm();
        test_longpress();
        test_midop_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
